// File: rtl/sw_pkg.sv
// Shared Smith-Waterman datapath definitions: symbol width, EOS token and
// small elaboration/pointer helpers used by the query-symbol FIFO.
package sw_pkg;

  localparam int SYM_W = 3;
  localparam logic [SYM_W-1:0] EOS_TOKEN = '0;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return res;
  endfunction

  // Modulo-depth pointer advance; inc never exceeds 2 and depth is at least 2,
  // so a single conditional subtraction always lands back in range.
  function automatic int ptr_add(input int ptr, input int inc, input int depth);
    int sum;
    sum = ptr + inc;
    if (sum >= depth) begin
      sum = sum - depth;
    end
    return sum;
  endfunction

endpackage

// File: rtl/eos_detect.sv
// Tracks whether the current loader sequence carried any valid symbol and
// raises a push request for valid symbols or for the single EOS event.
module eos_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic flush_i,
  input  logic valid_i,
  input  logic pouring_i,
  input  logic pouring_last_i,
  output logic push_req_o
);

  logic got_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      got_data <= 1'b0;
    end else if (flush_i) begin
      got_data <= 1'b0;
    end else begin
      got_data <= got_data ? pouring_i : valid_i;
    end
  end

  // A falling pouring edge on a sequence that carried no valid symbol emits one EOS token.
  assign push_req_o = valid_i | (pouring_last_i & ~pouring_i & ~got_data);

endmodule

// File: rtl/query_sym_fifo.sv
// Query-symbol FIFO between the query loader and the PE-array feeder: captures
// symbols plus EOS tokens and presents up to two registered head entries.
module query_sym_fifo
  import sw_pkg::*;
#(
  parameter  int DATA_W    = SYM_W,
  parameter  int DEPTH     = 16,
  parameter  int AF_THRESH = DEPTH - 2,
  localparam int LVL_W     = clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pouring_i,
  input  logic              pouring_last_i,
  input  logic [1:0]        pop_i,
  output logic [DATA_W-1:0] q0_o,
  output logic [DATA_W-1:0] q1_o,
  output logic [DATA_W-1:0] next_q0_ow,
  output logic [LVL_W-1:0]  level_o,
  output logic              full_o,
  output logic              almost_full_o,
  output logic              ready_one_o,
  output logic              ready_two_o,
  output logic              err_o
);

  localparam int PTR_W = clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [LVL_W-1:0]  level;

  logic              push_req;
  logic              accept;
  logic              err_set;
  logic [1:0]        pe;
  logic [DATA_W-1:0] wr_val;
  logic [PTR_W-1:0]  rd_nxt;
  logic [PTR_W-1:0]  rd1_nxt;
  logic [PTR_W-1:0]  wr_nxt;
  logic [LVL_W-1:0]  level_nxt;
  logic [DATA_W-1:0] head0;
  logic [DATA_W-1:0] head1;
  logic [DATA_W-1:0] q0_nxt;
  logic [DATA_W-1:0] q1_nxt;

  eos_detect u_eos_detect (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush_i),
    .valid_i        (data_i[DATA_W-1]),
    .pouring_i      (pouring_i),
    .pouring_last_i (pouring_last_i),
    .push_req_o     (push_req)
  );

  assign wr_val = data_i[DATA_W-1] ? data_i : DATA_W'(EOS_TOKEN);

  always_comb begin
    pe      = 2'd0;
    err_set = 1'b0;
    if (pop_i == 2'd3) begin
      err_set = 1'b1;
    end else if (LVL_W'(pop_i) > level) begin
      err_set = 1'b1;
      pe      = 2'(level);
    end else begin
      pe = pop_i;
    end

    // A full FIFO still takes a push when the same cycle frees an entry.
    accept = push_req && ((level < LVL_W'(DEPTH)) || (pe != 2'd0));
    if (push_req && !accept) begin
      err_set = 1'b1;
    end

    level_nxt = level + LVL_W'(accept) - LVL_W'(pe);
    rd_nxt    = PTR_W'(ptr_add(int'(rd_ptr), int'(pe), DEPTH));
    wr_nxt    = accept ? PTR_W'(ptr_add(int'(wr_ptr), 1, DEPTH)) : wr_ptr;

    if (flush_i) begin
      accept    = 1'b0;
      err_set   = 1'b0;
      level_nxt = '0;
      rd_nxt    = '0;
      wr_nxt    = '0;
    end
  end

  // Head lookup after this edge, forwarding the entry being written this cycle.
  always_comb begin
    rd1_nxt = PTR_W'(ptr_add(int'(rd_nxt), 1, DEPTH));
    head0   = (accept && (wr_ptr == rd_nxt))  ? wr_val : mem[rd_nxt];
    head1   = (accept && (wr_ptr == rd1_nxt)) ? wr_val : mem[rd1_nxt];
    q0_nxt  = (level_nxt >= LVL_W'(1)) ? head0 : '0;
    q1_nxt  = (level_nxt >= LVL_W'(2)) ? head1 : '0;
  end

  assign next_q0_ow = q0_nxt;
  assign level_o    = level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (accept) begin
      mem[wr_ptr] <= wr_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      level         <= '0;
      q0_o          <= '0;
      q1_o          <= '0;
      full_o        <= 1'b0;
      almost_full_o <= 1'b0;
      ready_one_o   <= 1'b0;
      ready_two_o   <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      rd_ptr        <= rd_nxt;
      wr_ptr        <= wr_nxt;
      level         <= level_nxt;
      q0_o          <= q0_nxt;
      q1_o          <= q1_nxt;
      full_o        <= (level_nxt == LVL_W'(DEPTH));
      almost_full_o <= (int'(level_nxt) >= AF_THRESH);
      ready_one_o   <= (level_nxt >= LVL_W'(1));
      ready_two_o   <= (level_nxt >= LVL_W'(2));
      err_o         <= err_o | err_set;
    end
  end

endmodule

// File: doc/query_sym_fifo.md
Name: query_sym_fifo

Overview:
- Parametrised query-symbol FIFO that sits between the query loader and the PE-array feeder in the Smith-Waterman datapath.
- Captures valid symbols and inserts one zero end-of-sequence (EOS) token when pouring ends without data.
- Delivers 0, 1 or 2 symbols per cycle from registered head outputs; adds level, almost-full, flush and a sticky error flag.

Parameters:
- DATA_W, 3, symbol width including valid bit; bit DATA_W-1 is the valid bit.
- DEPTH, 16, number of entries; any value >= 2, power of two not required.
- AF_THRESH, DEPTH-2, level at or above which almost_full_o asserts.
- LVL_W, clog2(DEPTH+1), derived width of the level counter; not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous clear of contents, pointers and tracking state.
- data_i  in  DATA_W  input symbol; MSB set marks a valid symbol.
- pouring_i  in  1  loader is currently streaming a sequence.
- pouring_last_i  in  1  pouring_i value from the previous loader cycle.
- pop_i  in  2  number of entries to consume this cycle: 0, 1 or 2; 3 is illegal.
- q0_o  out  DATA_W  registered head entry.
- q1_o  out  DATA_W  registered head+1 entry.
- next_q0_ow  out  DATA_W  combinational next-cycle head; equals the value q0_o takes at the next edge.
- level_o  out  LVL_W  registered entry count.
- full_o, almost_full_o, ready_one_o, ready_two_o  out  1 each  registered; asserted when level = DEPTH, level >= AF_THRESH, level >= 1 and level >= 2 respectively.
- err_o  out  1  sticky overflow/underflow/illegal-pop flag.

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0; level, read_ptr, write_ptr, got_data and err are 0; all storage entries are 0.
- Tracker: got_data_next = got_data ? pouring_i : data_i[MSB].
- Push request: data_i[MSB] | (pouring_last_i & ~pouring_i & ~got_data). The second term is the EOS event.
- Write value: data_i when the MSB is set, otherwise all zeros.
- Effective pop count: pe = min(pop_i, level). If pop_i = 3: pe = 0 and err is set. If pop_i > level: err is set.
- Push accept: push request & (level < DEPTH | pe > 0).
  - A push while full is accepted if the same cycle frees an entry.
  - A rejected push is dropped and sets err.
- Level update: level_next = level + accept - pe.
- Pointer wrap: write_ptr advances by 1 and read_ptr by pe, both modulo DEPTH. Example: read_ptr = DEPTH-1 with pe = 2 gives 1.
- Push to empty with a same-cycle pop: pe = 0 because level is 0; the pushed entry becomes the head at the next edge.
- All registered outputs (q0_o, q1_o, flags, level_o) are computed from next-state values, so they give one-cycle visibility of state after the edge.
- Latency: a pushed symbol appears on q0_o at the first edge after it is written, if the FIFO was empty.
- Head output masking: q0_o = 0 when level_next < 1; q1_o = 0 when level_next < 2. Stale entries never appear on the outputs.
- Flush: has priority over push and pop in the same cycle.
  - Clears level, both pointers and got_data; outputs go to 0 next cycle.
  - Storage contents need not be cleared.
  - err is not cleared; it clears only on reset.
- Reset mid-operation: immediate return to the reset state; no partial writes survive.

Decomposition:
- Shared package (sw_pkg): SYM_W = 3, EOS_TOKEN = all zeros, a clog2 function, and a ptr_add(ptr, inc, DEPTH) modulo-wrap function.
- One natural sub-module: eos_detect, holding the got_data register and generating the push-request term. The FIFO core stays in query_sym_fifo.

Test Plan:
- Push 3'b101, 3'b110, 3'b111 on consecutive cycles, pop_i = 0 -> q0_o = 101, q1_o = 110, level_o = 3, ready_two_o = 1, err_o = 0.
- pouring_i 1->0 with data_i MSB never set -> exactly one zero entry written, level_o = 1, q0_o = 000.
- Same fall after one valid symbol was seen -> no EOS entry written.
- DEPTH = 5: fill to 5, then push 3'b100 with pop_i = 1 -> accepted, level_o = 5, full_o = 1, err_o = 0.
- Next cycle, push with pop_i = 0 -> entry dropped, err_o = 1, level_o stays 5.
- DEPTH = 5: read_ptr at 4, level 3, pop_i = 2 -> read_ptr = 1, level_o = 1, q1_o = 0.
- level 1, pop_i = 2 -> level_o = 0, err_o = 1, q0_o = 0.
- Separately, pop_i = 3 with level 4 -> level_o unchanged, err_o = 1.
- flush_i = 1 together with a push at level 4 -> level_o = 0, q0_o = 0, err_o retains its prior value.
- Assert rst_n = 0 mid-stream -> all outputs 0 without waiting for a clock edge.
